// File: rtl/sfx_sequencer_if.sv
// Game-event / tone bus between the game FSM (master) and the sound-effect sequencer (slave).
// Events are plain levels sampled every clock; there is no valid/ready handshake on this bus.
interface sfx_sequencer_if;
    logic       ev_start;
    logic       ev_score;
    logic       ev_lose;
    logic       mute;
    logic [3:0] note_code;
    logic       busy;
    logic       q_full;
    logic [7:0] drop_cnt;
    logic [1:0] dbg_state;

    modport master (
        output ev_start, ev_score, ev_lose, mute,
        input  note_code, busy, q_full, drop_cnt, dbg_state
    );

    modport slave (
        input  ev_start, ev_score, ev_lose, mute,
        output note_code, busy, q_full, drop_cnt, dbg_state
    );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: queues game-event edges in a small FIFO and plays each as a fixed note melody.
// Optional macro SFX_LOSE_PREEMPT_EN: a lose edge flushes the queue and aborts the current melody.
module sfx_sequencer #(
    parameter int unsigned NOTE_TICKS = 16_777_216,
    parameter int unsigned GAP_TICKS  = 1_048_576,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sfx_sequencer_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] QDEPTH_C  = QDEPTH[PW:0];
    localparam logic [31:0] NOTE_LAST = NOTE_TICKS - 1;
    localparam logic [31:0] GAP_LAST  = GAP_TICKS - 1;
    localparam logic [1:0]  ID_START  = 2'd1;
    localparam logic [1:0]  ID_SCORE  = 2'd2;
    localparam logic [1:0]  ID_LOSE   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_t;

    logic          prev_start_q, prev_score_q, prev_lose_q;
    logic          rise_start, rise_score, rise_lose;
    logic          push, accept, pop, preempt, fifo_full, fifo_nonempty;
    logic [1:0]    push_id, head_id, n_rise, over_drop, n_drop;
    logic [1:0]    mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          q_full_q;
    logic [7:0]    drop_cnt_q;
    logic [8:0]    drop_sum;

    state_t        state_q;
    logic [1:0]    id_q;
    logic [2:0]    idx_q, idx_next;
    logic [31:0]   tick_q;
    logic [3:0]    note_q;
    logic          busy_q;

    function automatic logic [3:0] rom(input logic [1:0] id, input logic [2:0] idx);
        logic [3:0] code;
        code = 4'd0;
        case (id)
            ID_START: if (idx < 3'd5) code = {1'b0, idx} + 4'd1;
            ID_SCORE: if (idx < 3'd3) code = {1'b0, idx[1:0], 1'b1};
            ID_LOSE:  if (idx < 3'd5) code = 4'd5 - {1'b0, idx};
            default:  code = 4'd0;
        endcase
        return code;
    endfunction

    assign rise_start = bus.ev_start & ~prev_start_q;
    assign rise_score = bus.ev_score & ~prev_score_q;
    assign rise_lose  = bus.ev_lose  & ~prev_lose_q;

    assign push    = rise_start | rise_score | rise_lose;
    assign push_id = rise_lose ? ID_LOSE : (rise_start ? ID_START : ID_SCORE);

`ifdef SFX_LOSE_PREEMPT_EN
    assign preempt = rise_lose;
`else
    assign preempt = 1'b0;
`endif

    assign fifo_full     = (count_q == QDEPTH_C);
    assign fifo_nonempty = (count_q != '0);
    // A preempting lose replaces the whole queue, so the LOAD it forces must not pop anything stale.
    assign pop     = (state_q == S_LOAD) && !preempt;
    assign accept  = push && (preempt || !fifo_full || pop);
    assign head_id = mem_q[rd_ptr_q];

    assign n_rise    = {1'b0, rise_start} + {1'b0, rise_score} + {1'b0, rise_lose};
    assign over_drop = (n_rise != 2'd0) ? n_rise - 2'd1 : 2'd0;
    assign n_drop    = over_drop + {1'b0, push && !accept};
    assign drop_sum  = {1'b0, drop_cnt_q} + {7'd0, n_drop};

    always_comb begin
        count_d = count_q;
        if (preempt) begin
            count_d = {{PW{1'b0}}, 1'b1};
        end else begin
            if (accept) count_d = count_d + 1'b1;
            if (pop)    count_d = count_d - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (preempt)     mem_q[rd_ptr_q] <= ID_LOSE;
        else if (accept) mem_q[wr_ptr_q] <= push_id;
    end

    // History regs reset high so a level already asserted at reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_start_q <= 1'b1;
            prev_score_q <= 1'b1;
            prev_lose_q  <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            q_full_q     <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            prev_start_q <= bus.ev_start;
            prev_score_q <= bus.ev_score;
            prev_lose_q  <= bus.ev_lose;
            if (preempt) begin
                wr_ptr_q <= rd_ptr_q + 1'b1;
            end else begin
                if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            q_full_q   <= (count_d == QDEPTH_C);
            drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign idx_next = idx_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= 2'd0;
            idx_q   <= 3'd0;
            tick_q  <= 32'd0;
            note_q  <= 4'd0;
            busy_q  <= 1'b0;
        end else if (preempt) begin
            state_q <= S_LOAD;
            tick_q  <= 32'd0;
            note_q  <= 4'd0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    note_q <= 4'd0;
                    if (fifo_nonempty) begin
                        state_q <= S_LOAD;
                        tick_q  <= 32'd0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    id_q    <= head_id;
                    idx_q   <= 3'd0;
                    tick_q  <= 32'd0;
                    state_q <= S_NOTE;
                    note_q  <= bus.mute ? 4'd0 : rom(head_id, 3'd0);
                end
                S_NOTE: begin
                    // Re-evaluated every cycle so mute/unmute takes effect on the next clock.
                    if (tick_q == NOTE_LAST) begin
                        state_q <= S_GAP;
                        tick_q  <= 32'd0;
                        note_q  <= 4'd0;
                    end else begin
                        tick_q <= tick_q + 32'd1;
                        note_q <= bus.mute ? 4'd0 : rom(id_q, idx_q);
                    end
                end
                S_GAP: begin
                    note_q <= 4'd0;
                    if (tick_q == GAP_LAST) begin
                        tick_q <= 32'd0;
                        idx_q  <= idx_next;
                        if (rom(id_q, idx_next) == 4'd0) begin
                            state_q <= fifo_nonempty ? S_LOAD : S_IDLE;
                            busy_q  <= fifo_nonempty;
                        end else begin
                            state_q <= S_NOTE;
                            note_q  <= bus.mute ? 4'd0 : rom(id_q, idx_next);
                        end
                    end else begin
                        tick_q <= tick_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    note_q  <= 4'd0;
                end
            endcase
        end
    end

    assign bus.note_code = note_q;
    assign bus.busy      = busy_q;
    assign bus.q_full    = q_full_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.dbg_state = state_q;
endmodule
